// File: rtl/dac_pkg.sv
// dac_pkg: shared DAC serial-frame constants, FSM state enum and (port, lane, bit) to word-index mapping
package dac_pkg;
  localparam int PORTS      = 12;
  localparam int LANES      = 8;
  localparam int CODE_W     = 8;
  localparam int CNT_W      = 16;
  localparam int FRAME_BITS = 16;
  localparam int PD_BITS    = 2;
  localparam int PAD_BITS   = 6;
  localparam int NLANES     = PORTS * LANES;
  localparam int WORD_W     = NLANES * CODE_W;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} rx_state_e;
  function automatic int word_idx(input int p, input int l, input int b);
    return l * PORTS * CODE_W + p * CODE_W + b;
  endfunction
endpackage

// File: rtl/dac_frame_rx_if.sv
// dac_frame_rx_if: receiver bus (ACTIVE_N, CLR_ERR, SYNC_IN, SDIN_IN in; NMBR_RX, FRAME_VALID, FRAME_CNT, LEN/PD/PAD_ERR out; DAC_RX_CMP_EN adds NMBR_EXP, CMP_ERR, CMP_CNT)
interface dac_frame_rx_if;
  import dac_pkg::*;
  logic              ACTIVE_N;
  logic              CLR_ERR;
  logic              SYNC_IN;
  logic [NLANES-1:0] SDIN_IN;
  logic [WORD_W-1:0] NMBR_RX;
  logic              FRAME_VALID;
  logic [CNT_W-1:0]  FRAME_CNT;
  logic              LEN_ERR;
  logic              PD_ERR;
  logic              PAD_ERR;
`ifdef DAC_RX_CMP_EN
  logic [WORD_W-1:0] NMBR_EXP;
  logic              CMP_ERR;
  logic [CNT_W-1:0]  CMP_CNT;
`endif
  modport master (
    output ACTIVE_N, CLR_ERR, SYNC_IN, SDIN_IN,
`ifdef DAC_RX_CMP_EN
    output NMBR_EXP,
    input  CMP_ERR, CMP_CNT,
`endif
    input  NMBR_RX, FRAME_VALID, FRAME_CNT, LEN_ERR, PD_ERR, PAD_ERR
  );
  modport slave (
    input  ACTIVE_N, CLR_ERR, SYNC_IN, SDIN_IN,
`ifdef DAC_RX_CMP_EN
    input  NMBR_EXP,
    output CMP_ERR, CMP_CNT,
`endif
    output NMBR_RX, FRAME_VALID, FRAME_CNT, LEN_ERR, PD_ERR, PAD_ERR
  );
endinterface

// File: rtl/dac_rx_lane.sv
// dac_rx_lane: one lane's 16-bit frame shifter (SCLK, RESET_N, en, d in; code MSB-at-0, pd_nz, pad_nz out)
module dac_rx_lane
  import dac_pkg::*;
(
  input  logic              SCLK,
  input  logic              RESET_N,
  input  logic              en,
  input  logic              d,
  output logic [CODE_W-1:0] code,
  output logic              pd_nz,
  output logic              pad_nz
);
  logic [FRAME_BITS-1:0] sr;
  always_ff @(posedge SCLK)
    if (!RESET_N) sr <= '0;
    else if (en) sr <= {sr[FRAME_BITS-2:0], d};
  for (genvar b = 0; b < CODE_W; b++) begin : g_code
    assign code[b] = sr[FRAME_BITS-1-PD_BITS-b];
  end
  assign pd_nz  = |sr[FRAME_BITS-1 -: PD_BITS];
  assign pad_nz = |sr[PAD_BITS-1:0];
endmodule

// File: rtl/dac_frame_rx.sv
// dac_frame_rx: serial DAC frame receiver (SCLK, RESET_N, dac_frame_rx_if.slave bus); DAC_RX_CMP_EN enables expected-word compare
module dac_frame_rx
  import dac_pkg::*;
(
  input logic           SCLK,
  input logic           RESET_N,
  dac_frame_rx_if.slave bus
);
  rx_state_e         state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              shift_en, commit, good;
  logic              fv_q, len_q, pd_q, pad_q;
  logic [NLANES-1:0] pd_nz, pad_nz;
  logic [CODE_W-1:0] code [NLANES];
  logic [WORD_W-1:0] word, nmbr_q;
  logic [CNT_W-1:0]  fcnt_q;
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    dac_rx_lane u_lane (
      .SCLK    (SCLK),
      .RESET_N (RESET_N),
      .en      (shift_en),
      .d       (bus.SDIN_IN[k]),
      .code    (code[k]),
      .pd_nz   (pd_nz[k]),
      .pad_nz  (pad_nz[k])
    );
    for (genvar b = 0; b < CODE_W; b++) begin : g_bit
      assign word[word_idx(k / LANES, k % LANES, b)] = code[k][b];
    end
  end
  always_comb begin
    shift_en = bus.ACTIVE_N & ~bus.SYNC_IN;
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    if (bus.ACTIVE_N) begin
      state_d = bus.SYNC_IN ? (state_q == ST_SHIFT ? ST_COMMIT : ST_IDLE) : ST_SHIFT;
      cnt_d   = bus.SYNC_IN ? cnt_q : state_q != ST_SHIFT ? 5'd1 : cnt_q == 5'd17 ? cnt_q : cnt_q + 5'd1;
      commit  = bus.SYNC_IN && state_q == ST_SHIFT;
    end
  end
  assign good = commit && cnt_q == 5'd16;
  always_ff @(posedge SCLK)
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_ff @(posedge SCLK)
    if (!RESET_N) begin
      fv_q   <= 1'b0;
      nmbr_q <= '0;
      fcnt_q <= '0;
      len_q  <= 1'b0;
      pd_q   <= 1'b0;
      pad_q  <= 1'b0;
    end else if (bus.ACTIVE_N) begin
      fv_q   <= good;
      nmbr_q <= good ? word : nmbr_q;
      fcnt_q <= fcnt_q + CNT_W'(good);
      len_q  <= (commit && !good) || (len_q && !bus.CLR_ERR);
      pd_q   <= (good && |pd_nz) || (pd_q && !bus.CLR_ERR);
      pad_q  <= (good && |pad_nz) || (pad_q && !bus.CLR_ERR);
    end else begin
      fv_q   <= 1'b0;
    end
  assign bus.NMBR_RX     = nmbr_q;
  assign bus.FRAME_VALID = fv_q & bus.ACTIVE_N;
  assign bus.FRAME_CNT   = fcnt_q;
  assign bus.LEN_ERR     = len_q;
  assign bus.PD_ERR      = pd_q;
  assign bus.PAD_ERR     = pad_q;
`ifdef DAC_RX_CMP_EN
  logic             cmp_q, miss;
  logic [CNT_W-1:0] ccnt_q;
  assign miss = good && word != bus.NMBR_EXP;
  always_ff @(posedge SCLK)
    if (!RESET_N) begin
      cmp_q  <= 1'b0;
      ccnt_q <= '0;
    end else if (bus.ACTIVE_N) begin
      cmp_q  <= miss || (cmp_q && !bus.CLR_ERR);
      ccnt_q <= ccnt_q + CNT_W'(miss);
    end
  assign bus.CMP_ERR = cmp_q;
  assign bus.CMP_CNT = ccnt_q;
`endif
endmodule

// File: tb/tb_dac_frame_rx.sv
// tb_dac_frame_rx: randomized self-checking bench for dac_frame_rx against a frame-level reference model
module tb_dac_frame_rx;
  import dac_pkg::*;
  logic SCLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 SCLK = ~SCLK;
  dac_frame_rx_if bus();
  dac_frame_rx dut (.SCLK(SCLK), .RESET_N(RESET_N), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  logic rnd = 1'b0;
  logic [CODE_W-1:0] f_code [NLANES];
  logic [1:0]        f_pd   [NLANES];
  logic [5:0]        f_pad  [NLANES];
  int                run_len;
  logic [NLANES-1:0] smp [FRAME_BITS];
  logic [WORD_W-1:0] m_word;
  logic              m_valid, m_len, m_pd, m_pad, m_cmp;
  logic [CNT_W-1:0]  m_cnt, m_ccnt;
  task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_edge();
    logic [WORD_W-1:0] w;
    logic len_set, pd_set, pad_set, cmp_set, padb;
    len_set = 0; pd_set = 0; pad_set = 0; cmp_set = 0; padb = 0; w = '0;
    if (!RESET_N) begin
      run_len = 0; m_word = '0; m_valid = 0; m_cnt = '0;
      m_len = 0; m_pd = 0; m_pad = 0; m_cmp = 0; m_ccnt = '0;
    end else if (!bus.ACTIVE_N) begin
      m_valid = 0;
    end else begin
      m_valid = 0;
      if (!bus.SYNC_IN) begin
        if (run_len < FRAME_BITS) smp[run_len] = bus.SDIN_IN;
        run_len++;
      end else if (run_len > 0) begin
        if (run_len == FRAME_BITS) begin
          for (int k = 0; k < NLANES; k++)
            for (int b = 0; b < CODE_W; b++)
              w[(k % LANES) * PORTS * CODE_W + (k / LANES) * CODE_W + b] = smp[PD_BITS + b][k];
          for (int i = FRAME_BITS - PAD_BITS; i < FRAME_BITS; i++) padb |= |smp[i];
          pd_set = |(smp[0] | smp[1]);
          pad_set = padb;
`ifdef DAC_RX_CMP_EN
          cmp_set = w != bus.NMBR_EXP;
`endif
          m_word = w; m_valid = 1; m_cnt++;
          if (cmp_set) m_ccnt++;
        end else len_set = 1;
        run_len = 0;
      end
      m_len = len_set | (m_len & ~bus.CLR_ERR);
      m_pd  = pd_set  | (m_pd  & ~bus.CLR_ERR);
      m_pad = pad_set | (m_pad & ~bus.CLR_ERR);
      m_cmp = cmp_set | (m_cmp & ~bus.CLR_ERR);
    end
  endtask
  task automatic check_all();
    check("valid", bus.FRAME_VALID, m_valid);
    check("frame_cnt", bus.FRAME_CNT, m_cnt);
    check("len_err", bus.LEN_ERR, m_len);
    check("pd_err", bus.PD_ERR, m_pd);
    check("pad_err", bus.PAD_ERR, m_pad);
    check("nmbr_rx", bus.NMBR_RX, m_word);
`ifdef DAC_RX_CMP_EN
    check("cmp_err", bus.CMP_ERR, m_cmp);
    check("cmp_cnt", bus.CMP_CNT, m_ccnt);
`endif
  endtask
  task automatic step(input logic s, input logic [NLANES-1:0] d);
    if (rnd) begin
      bus.ACTIVE_N = ($urandom % 8) != 0;
      bus.CLR_ERR  = ($urandom % 10) == 0;
    end
    bus.SYNC_IN = s;
    bus.SDIN_IN = d;
    @(posedge SCLK);
    model_edge();
    #1;
    check_all();
  endtask
  function automatic logic [NLANES-1:0] fbit(input int i);
    logic [NLANES-1:0] v;
    for (int k = 0; k < NLANES; k++)
      v[k] = i < 2 ? f_pd[k][1 - i] : i < 10 ? f_code[k][9 - i] : i < 16 ? f_pad[k][15 - i] : 1'($urandom);
    return v;
  endfunction
  task automatic set_frame(input int mode);
    for (int k = 0; k < NLANES; k++) begin
      f_code[k] = mode == 0 ? 8'hA5 : mode == 1 ? 8'(k) : 8'($urandom);
      f_pd[k] = 2'b00;
      f_pad[k] = 6'b000000;
    end
  endtask
  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) step(1'b0, fbit(i));
    step(1'b1, '0);
  endtask
  task automatic clear_err();
    bus.CLR_ERR = 1'b1;
    step(1'b1, '0);
    bus.CLR_ERR = 1'b0;
  endtask
  task automatic do_reset();
    RESET_N = 1'b0;
    repeat (2) step(1'b1, '0);
    RESET_N = 1'b1;
    step(1'b1, '0);
  endtask
`ifdef DAC_RX_CMP_EN
  function automatic logic [WORD_W-1:0] frame_word();
    logic [WORD_W-1:0] e;
    e = '0;
    for (int k = 0; k < NLANES; k++)
      for (int b = 0; b < CODE_W; b++)
        e[(k % LANES) * PORTS * CODE_W + (k / LANES) * CODE_W + b] = f_code[k][CODE_W - 1 - b];
    return e;
  endfunction
`endif
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.ACTIVE_N = 1'b1;
    bus.CLR_ERR  = 1'b0;
    bus.SYNC_IN  = 1'b1;
    bus.SDIN_IN  = '0;
`ifdef DAC_RX_CMP_EN
    bus.NMBR_EXP = '0;
`endif
    do_reset();
    check("reset_cnt", bus.FRAME_CNT, 0);
    set_frame(0);
    send_frame(16);
    check("a5_valid", bus.FRAME_VALID, 1);
    check("a5_word", bus.NMBR_RX, {96{8'hA5}});
    check("a5_cnt", bus.FRAME_CNT, 1);
    check("a5_noerr", {bus.LEN_ERR, bus.PD_ERR, bus.PAD_ERR}, 0);
    set_frame(1);
    repeat (10) send_frame(16);
    check("b2b_cnt", bus.FRAME_CNT, 11);
    set_frame(2);
    send_frame(12);
    check("len12_err", bus.LEN_ERR, 1);
    check("len12_cnt", bus.FRAME_CNT, 11);
    clear_err();
    check("len_clr", bus.LEN_ERR, 0);
    send_frame(20);
    check("len20_err", bus.LEN_ERR, 1);
    clear_err();
    set_frame(2);
    f_pd[3 * LANES + 5] = 2'b10;
    send_frame(16);
    check("pd_err_set", bus.PD_ERR, 1);
    check("pd_commit_cnt", bus.FRAME_CNT, 12);
    f_pd[3 * LANES + 5] = 2'b00;
    f_pad[40] = 6'b000010;
    send_frame(16);
    check("pad_err_set", bus.PAD_ERR, 1);
    clear_err();
    check("clr_both", {bus.PD_ERR, bus.PAD_ERR}, 0);
    set_frame(2);
    for (int i = 0; i < 16; i++) step(1'b0, fbit(i));
    bus.ACTIVE_N = 1'b0;
    repeat (3) step(1'b1, '0);
    check("hold_valid", bus.FRAME_VALID, 0);
    check("hold_cnt", bus.FRAME_CNT, 13);
    bus.ACTIVE_N = 1'b1;
    step(1'b1, '0);
    check("resume_valid", bus.FRAME_VALID, 1);
    for (int i = 0; i < 7; i++) step(1'b0, fbit(i));
    RESET_N = 1'b0;
    step(1'b0, fbit(7));
    RESET_N = 1'b1;
    check("midrst_cnt", bus.FRAME_CNT, 0);
    check("midrst_word", bus.NMBR_RX, 0);
    step(1'b1, '0);
    send_frame(16);
    check("postrst_cnt", bus.FRAME_CNT, 1);
    check("postrst_len", bus.LEN_ERR, 0);
`ifdef DAC_RX_CMP_EN
    do_reset();
    set_frame(2);
    bus.NMBR_EXP = frame_word() ^ (WORD_W'(1) << 300);
    send_frame(16);
    check("cmp_err_set", bus.CMP_ERR, 1);
    check("cmp_cnt_one", bus.CMP_CNT, 1);
    set_frame(2);
    bus.NMBR_EXP = frame_word();
    send_frame(16);
    check("cmp_cnt_hold", bus.CMP_CNT, 1);
`endif
    rnd = 1'b1;
    repeat (40) begin
      set_frame(2);
      if ($urandom % 6 == 0) f_pd[$urandom % NLANES] = 2'($urandom_range(1, 3));
      if ($urandom % 6 == 0) f_pad[$urandom % NLANES] = 6'($urandom_range(1, 63));
`ifdef DAC_RX_CMP_EN
      bus.NMBR_EXP = ($urandom % 2) ? frame_word() : WORD_W'($urandom);
`endif
      send_frame(($urandom % 3 == 0) ? int'($urandom_range(10, 20)) : 16);
      repeat ($urandom_range(0, 2)) step(1'b1, '0);
    end
    rnd = 1'b0;
    bus.ACTIVE_N = 1'b1;
    bus.CLR_ERR = 1'b0;
    repeat (3) step(1'b1, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
